// File: rtl/led_fx.sv
// Multi-channel LED effect driver: per-channel off / blink / PWM / breathe modes.
// Config writes land in a shadow bank that is copied to the active bank at each PWM period boundary.
module led_fx #(
  parameter  int CHANNELS = 3,
  parameter  int CNT_W    = 26,
  parameter  int PWM_W    = 8,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int TAP_W    = $clog2(CNT_W)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [PWM_W-1:0]    cfg_duty,
  input  logic [TAP_W-1:0]    cfg_tap,
  output logic [CHANNELS-1:0] led,
  output logic                frame_tick
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_BLINK   = 2'b01,
    MODE_PWM     = 2'b10,
    MODE_BREATHE = 2'b11
  } mode_e;

  typedef struct packed {
    mode_e             mode;
    logic [PWM_W-1:0]  duty;
    logic [TAP_W-1:0]  tap;
  } cfg_t;

  localparam logic [CH_W:0]    CH_LIMIT  = (CH_W + 1)'(CHANNELS);
  localparam logic [TAP_W:0]   TAP_LIMIT = (TAP_W + 1)'(CNT_W);
  localparam logic [TAP_W-1:0] TAP_MAX   = TAP_W'(CNT_W - 1);
  localparam logic [PWM_W-1:0] LVL_ONE   = PWM_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Legacy blink default: channel i follows counter bit CNT_W-1-i, floored at bit 0.
  function automatic cfg_t reset_cfg(input int idx);
    cfg_t c;
    int   t;
    t = CNT_W - 1 - idx;
    if (t < 0) t = 0;
    c.mode = MODE_BLINK;
    c.duty = '0;
    c.tap  = TAP_W'(t);
    return c;
  endfunction

  logic [CNT_W-1:0]    r_cnt;
  logic [CHANNELS-1:0] r_led;
  logic                r_frame_tick;
  cfg_t                r_shadow  [CHANNELS];
  cfg_t                r_active  [CHANNELS];
  logic [PWM_W-1:0]    r_level   [CHANNELS];
  logic [CHANNELS-1:0] r_dir_dn;

  logic [PWM_W-1:0]    w_phase;
  logic                w_boundary;
  logic                w_wr_ok;
  cfg_t                w_wr_cfg;
  logic [PWM_W-1:0]    w_level_nxt [CHANNELS];
  logic [CHANNELS-1:0] w_dir_dn_nxt;
  logic [CHANNELS-1:0] w_led_nxt;

  assign w_phase    = r_cnt[PWM_W-1:0];
  assign w_boundary = &w_phase;
  assign w_wr_ok    = cfg_we && ({1'b0, cfg_ch} < CH_LIMIT);

  always_comb begin
    w_wr_cfg.mode = mode_e'(cfg_mode);
    w_wr_cfg.duty = cfg_duty;
    w_wr_cfg.tap  = ({1'b0, cfg_tap} >= TAP_LIMIT) ? TAP_MAX : cfg_tap;
  end

  // Breathe ping-pong step; only committed at a period boundary.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      w_level_nxt[i]  = r_level[i];
      w_dir_dn_nxt[i] = r_dir_dn[i];
      if (r_active[i].mode != MODE_BREATHE) begin
        w_level_nxt[i]  = '0;
        w_dir_dn_nxt[i] = 1'b0;
      end else if (r_level[i] > r_active[i].duty) begin
        w_level_nxt[i]  = r_level[i] - LVL_ONE;
        w_dir_dn_nxt[i] = 1'b1;
      end else if (r_level[i] == '0 && r_active[i].duty == '0) begin
        w_level_nxt[i]  = '0;
        w_dir_dn_nxt[i] = 1'b0;
      end else if (!r_dir_dn[i]) begin
        if (r_level[i] == r_active[i].duty) begin
          w_level_nxt[i]  = r_level[i] - LVL_ONE;
          w_dir_dn_nxt[i] = 1'b1;
        end else begin
          w_level_nxt[i]  = r_level[i] + LVL_ONE;
          w_dir_dn_nxt[i] = (r_level[i] + LVL_ONE) == r_active[i].duty;
        end
      end else if (r_level[i] == '0) begin
        w_dir_dn_nxt[i] = 1'b0;
      end else begin
        w_level_nxt[i]  = r_level[i] - LVL_ONE;
        w_dir_dn_nxt[i] = (r_level[i] - LVL_ONE) != '0;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      w_led_nxt[i] = 1'b0;
      case (r_active[i].mode)
        MODE_BLINK:   w_led_nxt[i] = r_cnt[r_active[i].tap];
        MODE_PWM:     w_led_nxt[i] = w_phase < r_active[i].duty;
        MODE_BREATHE: w_led_nxt[i] = w_phase < r_level[i];
        default:      w_led_nxt[i] = 1'b0;
      endcase
    end
  end

  // NOTE: the config banks are a handful of flops, not a RAM, so they take the reset defaults directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_led        <= '0;
      r_frame_tick <= 1'b0;
      r_dir_dn     <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        r_shadow[i] <= reset_cfg(i);
        r_active[i] <= reset_cfg(i);
        r_level[i]  <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments, so the boundary copy below sees the pre-edge shadow value.
      r_cnt        <= r_cnt + CNT_ONE;
      r_led        <= w_led_nxt;
      r_frame_tick <= w_boundary;
      if (w_wr_ok) r_shadow[cfg_ch] <= w_wr_cfg;
      if (w_boundary) begin
        r_dir_dn <= w_dir_dn_nxt;
        for (int i = 0; i < CHANNELS; i++) begin
          r_active[i] <= r_shadow[i];
          r_level[i]  <= w_level_nxt[i];
        end
      end
    end
  end

  assign led        = r_led;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_led_fx.sv
// Directed bench for led_fx (CNT_W=10, PWM_W=4, CHANNELS=3) with an expected-value queue.
module tb_led_fx;
  localparam int CHANNELS = 3;
  localparam int CNT_W    = 10;
  localparam int PWM_W    = 4;
  localparam int PER      = 16;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b1;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_ch   = '0;
  logic [1:0] cfg_mode = '0;
  logic [3:0] cfg_duty = '0;
  logic [3:0] cfg_tap  = '0;
  logic [2:0] led;
  logic       frame_tick;

  int checks = 0;
  int errors = 0;
  int n_edge;
  string q_tag[$];
  int    q_exp[$];

  led_fx #(.CHANNELS(CHANNELS), .CNT_W(CNT_W), .PWM_W(PWM_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_duty(cfg_duty), .cfg_tap(cfg_tap), .led(led), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Edge count since reset release; equals the DUT counter value after each edge.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) n_edge <= 0;
    else        n_edge <= n_edge + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic drive_wr(input logic [1:0] ch, input logic [1:0] mode,
                          input logic [3:0] duty, input logic [3:0] tap);
    cfg_we = 1'b1; cfg_ch = ch; cfg_mode = mode; cfg_duty = duty; cfg_tap = tap;
  endtask

  task automatic expect_val(input string tag, input int val);
    q_tag.push_back(tag);
    q_exp.push_back(val);
  endtask

  task automatic check_next(input int obs);
    string tag;
    int    exp_v;
    checks++;
    if (q_exp.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %0d expected <none>", obs);
      return;
    end
    tag   = q_tag.pop_front();
    exp_v = q_exp.pop_front();
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Captures one full PWM period of led, starting right after a boundary edge.
  task automatic measure(output logic [2:0][15:0] pats, output int first);
    pats = '0;
    for (int k = 0; k < PER && (n_edge % PER) != 0; k++) tick();
    first = n_edge + 1;
    for (int j = 0; j < PER; j++) begin
      tick();
      for (int c = 0; c < CHANNELS; c++) pats[c][j] = led[c];
    end
  endtask

  function automatic logic [15:0] blink_pat(input int first, input int tap);
    logic [15:0] b;
    for (int j = 0; j < PER; j++) b[j] = (((first - 1 + j) >> tap) & 1) != 0;
    return b;
  endfunction

  function automatic logic [15:0] pwm_pat(input int n);
    logic [15:0] b;
    for (int j = 0; j < PER; j++) b[j] = (j < n);
    return b;
  endfunction

  initial begin
    logic [2:0][15:0] p;
    int first;
    int rise [3];
    int ft_first, ft_cnt, ft_off, hold, stray;
    int br_seq [16];

    // Reset state
    #1 rst_n = 1'b0;
    #11;
    expect_val("rst_led", 0);        check_next(int'(led));
    expect_val("rst_frame_tick", 0); check_next(int'(frame_tick));
    @(negedge clk) rst_n = 1'b1;

    // 1: default blink taps and frame tick cadence
    expect_val("t1_led0_first_rise", 513);
    expect_val("t1_led1_first_rise", 257);
    expect_val("t1_led2_first_rise", 129);
    expect_val("t1_tick_first", 16);
    expect_val("t1_tick_count", 33);
    expect_val("t1_tick_offgrid", 0);
    rise = '{-1, -1, -1};
    ft_first = -1; ft_cnt = 0; ft_off = 0;
    for (int k = 0; k < 530; k++) begin
      tick();
      for (int c = 0; c < CHANNELS; c++) if (rise[c] < 0 && led[c]) rise[c] = n_edge;
      if (frame_tick) begin
        ft_cnt++;
        if (ft_first < 0) ft_first = n_edge;
        if (n_edge % PER != 0) ft_off++;
      end
    end
    check_next(rise[0]); check_next(rise[1]); check_next(rise[2]);
    check_next(ft_first); check_next(ft_cnt); check_next(ft_off);

    // 2: PWM on ch1, written mid-period while its blink output is high
    while (n_edge < 776) tick();
    drive_wr(2'd1, 2'b10, 4'd5, 4'd0);
    expect_val("t2_blink_hold", 7);
    tick();
    hold = 0;
    for (int k = 0; k < 7; k++) begin
      tick();
      if (led[1]) hold++;
    end
    check_next(hold);
    measure(p, first);
    expect_val("t2_pwm5", int'(pwm_pat(5)));         check_next(int'(p[1]));
    expect_val("t2_ch0_blink", int'(blink_pat(first, 9))); check_next(int'(p[0]));
    expect_val("t2_ch2_blink", int'(blink_pat(first, 7))); check_next(int'(p[2]));
    drive_wr(2'd1, 2'b10, 4'd0, 4'd0);
    expect_val("t2_pwm0", 0);
    tick();
    measure(p, first);
    check_next(int'(p[1]));
    drive_wr(2'd1, 2'b10, 4'd15, 4'd0);
    expect_val("t2_pwm15", int'(pwm_pat(15)));
    tick();
    measure(p, first);
    check_next(int'(p[1]));

    // 3: write landing on the boundary edge is delayed by one period
    for (int k = 0; k < PER && (n_edge % PER) != PER - 1; k++) tick();
    drive_wr(2'd0, 2'b10, 4'd2, 4'd0);
    tick();
    measure(p, first);
    expect_val("t3_still_blink", int'(blink_pat(first, 9))); check_next(int'(p[0]));
    measure(p, first);
    expect_val("t3_applied_pwm2", int'(pwm_pat(2)));       check_next(int'(p[0]));

    // 4: breathe ping-pong, then peak lowered while at level 3
    br_seq = '{0, 1, 2, 3, 2, 1, 0, 1, 2, 3, 2, 1, 0, 1, 0, 1};
    drive_wr(2'd2, 2'b11, 4'd3, 4'd0);
    tick();
    for (int k = 0; k < 16; k++) begin
      if (k == 9) drive_wr(2'd2, 2'b11, 4'd1, 4'd0);
      expect_val($sformatf("t4_breathe_p%0d", k), int'(pwm_pat(br_seq[k])));
      measure(p, first);
      check_next(int'(p[2]));
    end

    // 5: out-of-range channel write is ignored; tap clamps to CNT_W-1
    drive_wr(2'd3, 2'b00, 4'd0, 4'd0);
    tick();
    measure(p, first);
    expect_val("t5_ch0_kept_a", int'(pwm_pat(2)));  check_next(int'(p[0]));
    expect_val("t5_ch1_kept_a", int'(pwm_pat(15))); check_next(int'(p[1]));
    expect_val("t5_ch2_kept_a", int'(pwm_pat(1)));  check_next(int'(p[2]));
    measure(p, first);
    expect_val("t5_ch0_kept_b", int'(pwm_pat(2)));  check_next(int'(p[0]));
    expect_val("t5_ch1_kept_b", int'(pwm_pat(15))); check_next(int'(p[1]));
    expect_val("t5_ch2_kept_b", int'(pwm_pat(0)));  check_next(int'(p[2]));
    for (int k = 0; k < 1100 && (n_edge & 1023) != 528; k++) tick();
    drive_wr(2'd1, 2'b01, 4'd0, 4'd15);
    tick();
    measure(p, first);
    expect_val("t5_tap_clamp", int'(blink_pat(first, 9))); check_next(int'(p[1]));

    // 6: async reset in the middle of a breathe ramp
    drive_wr(2'd0, 2'b01, 4'd0, 4'd0);
    tick();
    drive_wr(2'd2, 2'b00, 4'd0, 4'd0);
    tick();
    measure(p, first);
    expect_val("t6_ch0_tap0", int'(blink_pat(first, 0))); check_next(int'(p[0]));
    expect_val("t6_ch2_off", 0);                          check_next(int'(p[2]));
    drive_wr(2'd2, 2'b11, 4'd3, 4'd0);
    tick();
    for (int k = 0; k < 3; k++) begin
      expect_val($sformatf("t6_breathe_p%0d", k), int'(pwm_pat(k)));
      measure(p, first);
      check_next(int'(p[2]));
    end
    expect_val("t6_tick_pre", 1);  check_next(int'(frame_tick));
    expect_val("t6_led0_pre", 1);  check_next(int'(led[0]));
    #1 rst_n = 1'b0;
    #1;
    expect_val("t6_led_async", 0);  check_next(int'(led));
    expect_val("t6_tick_async", 0); check_next(int'(frame_tick));
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    expect_val("t6_led2_first_rise", 129);
    expect_val("t6_tick_first", 16);
    expect_val("t6_led01_quiet", 0);
    rise[2] = -1; ft_first = -1; stray = 0;
    for (int k = 0; k < 140; k++) begin
      tick();
      if (rise[2] < 0 && led[2]) rise[2] = n_edge;
      if (ft_first < 0 && frame_tick) ft_first = n_edge;
      if (led[1:0] != 2'b00) stray++;
    end
    check_next(rise[2]); check_next(ft_first); check_next(stray);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
